run_length_detector: RTL and testbench
======================================

Name: run_length_detector

Overview:
- Multi-channel, parametrised run-length detector. Each channel counts consecutive qualified samples at the target level and flags when the run reaches a runtime threshold.
- Generalises the single-channel fixed-length zero-run sensor:
  - N channels
  - selectable polarity
  - runtime threshold
  - one-shot or periodic pulse mode
  - sample-enable qualifier
- Sits between sensor input synchronisers and the event/interrupt aggregator.

Parameters:
- CH, 4, number of independent channels
- CNT_W, 4, width of run counter and threshold
- POLARITY, 0, sample level counted as "in run" (0 = count zeros, 1 = count ones)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  sample qualifier; channels advance only when 1
- in  input  CH  one sample bit per channel
- thresh  input  CNT_W  run length that triggers a hit; 0 treated as 1
- mode  input  1  0 = one-shot per run, 1 = periodic pulse every thresh samples while run continues
- pulse  output  CH  registered one-cycle hit strobe per channel
- active  output  CH  registered level, 1 while channel run length >= threshold
- any_pulse  output  1  registered OR of pulse

Behaviour:
- Reset: all channel FSMs go to IDLE, counters 0, pulse = 0, active = 0, any_pulse = 0. Reset dominates in_valid in the same cycle.
- in_valid = 0: no state or counter change; pulse forced 0 that cycle; active holds its value.
- Per-channel FSM, evaluated on each cycle with in_valid = 1. "hit" means in[i] == POLARITY. Effective threshold T = (thresh == 0) ? 1 : thresh.
  - IDLE, cnt = 0:
    - hit: cnt <= 1; go to FIRE if T == 1, else COUNT.
    - no hit: stay in IDLE.
  - COUNT:
    - hit: cnt <= cnt + 1; go to FIRE when cnt + 1 >= T, else stay in COUNT.
    - no hit: cnt <= 0; go to IDLE.
  - FIRE, the state entered on the sample that completed the run:
    - pulse[i] = 1 for exactly one clock.
    - active[i] = 1.
    - Next valid sample, hit: mode 0 -> HOLD; mode 1 -> cnt <= 1, go to FIRE if T == 1, else COUNT.
    - Next valid sample, no hit: cnt <= 0, active <= 0, go to IDLE.
  - HOLD (mode 0 only):
    - hit: stay in HOLD, no further pulse, active stays 1, cnt frozen.
    - no hit: go to IDLE, cnt <= 0, active <= 0.
- Latency: pulse and active are registered and assert in the cycle after the clock edge that sampled the completing bit.
- Counter is sized CNT_W and never wraps. The compare uses >=, and the counter stops advancing in FIRE and HOLD.
- thresh may change at any time; the new value applies from the next valid sample.
  - Lowering thresh below the current cnt while in COUNT fires on the next hit sample.
- mode may change at any time. Switching mode 0 -> 1 while in HOLD: the next hit restarts counting at cnt = 1 (same as leaving FIRE in mode 1).
- Reset mid-run aborts all runs; no pulse is emitted in the reset cycle or the cycle after.
- Channels are fully independent. Simultaneous hits on several channels each pulse in the same cycle; any_pulse = 1 once.

Optional Feature:
- Macro: RUN_LENGTH_DETECTOR_HITCNT_EN.
- Defined:
  - Adds output hit_cnt, width CH*8: one 8-bit saturating counter per channel, channel i at bits [8i+7:8i].
  - A counter increments in the same cycle its pulse[i] is 1.
  - Saturates at 255.
  - Cleared by reset.
  - Extra input hit_clr (1 bit) clears all counters synchronously; hit_clr has priority over a same-cycle increment.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- Defaults, thresh = 8, mode = 0, in_valid = 1. Drive ch0 = 0 for 8 cycles, then 1 -> pulse[0] = 1 exactly one cycle, after the 8th zero sample; active[0] = 1 until the cycle after the first 1 sample; any_pulse mirrors pulse[0].
- thresh = 8, mode = 0, ch1 = 0 for 20 cycles -> exactly one pulse[1] (after sample 8); active[1] high from sample 8 through sample 20.
- thresh = 3, mode = 1, ch2 = 0 for 9 cycles -> pulse[2] after samples 3, 6 and 9.
- thresh = 4, ch3 pattern 0,0,0,1,0,0,0,0 -> no pulse after sample 3; one pulse after sample 8. in_valid = 0 for 5 cycles in the middle of a run -> run extends by no samples and the pulse shifts by 5 cycles.
- thresh = 0, POLARITY = 1 instance, single 1 sample -> pulse one cycle later. Assert reset during a 6-of-8 run -> no pulse; a fresh run of 8 is then required.
- HITCNT_EN build: 300 periodic hits with thresh = 1, mode = 1 -> hit_cnt[0] = 255; hit_clr pulse -> 0.

Source files
------------

// File: rtl/run_length_detector.sv
// -----------------------------------------------------------------------------
// run_length_detector
//
// Multi-channel run-length detector. Every channel counts consecutive
// qualified samples at the POLARITY level and raises a one-cycle strobe when
// the run reaches the runtime threshold. In one-shot mode (mode = 0) a run
// fires once; in periodic mode (mode = 1) it fires again every thresh samples
// while the run continues. A threshold of 0 behaves as 1.
//
// Parameters:
//   CH        number of independent channels
//   CNT_W     width of the run counter and of thresh
//   POLARITY  sample level counted as "in run" (0 = zeros, 1 = ones)
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   in_valid   sample qualifier; channels advance only when 1
//   in         one sample bit per channel
//   thresh     run length that triggers a hit (0 treated as 1)
//   mode       0 = one-shot per run, 1 = periodic pulse
//   pulse      registered one-cycle hit strobe per channel
//   active     registered level, 1 while the run has reached the threshold
//   any_pulse  registered OR of pulse
//
// Optional feature, enabled by defining RUN_LENGTH_DETECTOR_HITCNT_EN:
//   hit_clr    clears every hit counter (wins over a same-cycle increment)
//   hit_cnt    8-bit saturating pulse counter per channel, channel i at
//              bits [8i+7:8i]; it counts up together with the pulse it sees
// -----------------------------------------------------------------------------
module run_length_detector #(
  parameter int CH       = 4,
  parameter int CNT_W    = 4,
  parameter bit POLARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [CH-1:0]        in,
  input  logic [CNT_W-1:0]     thresh,
  input  logic                 mode,
  output logic [CH-1:0]        pulse,
  output logic [CH-1:0]        active,
  output logic                 any_pulse
`ifdef RUN_LENGTH_DETECTOR_HITCNT_EN
  ,
  input  logic                 hit_clr,
  output logic [CH*8-1:0]      hit_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_FIRE,
    S_HOLD
  } state_t;

  logic [CNT_W-1:0] thresh_eff;
  logic             t_is_one;
  logic [CH-1:0]    pulse_d_vec;
  logic             any_pulse_q;

  assign thresh_eff = (thresh == '0) ? CNT_W'(1) : thresh;
  assign t_is_one   = (thresh_eff == CNT_W'(1));

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic             pulse_q, pulse_d;
    logic             active_q, active_d;
    logic             hit;

    assign hit     = (in[gi] == POLARITY);
    // One extra bit so the increment can never wrap before the compare.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pulse_d  = 1'b0;
      active_d = active_q;
      if (in_valid) begin
        if (!hit) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          active_d = 1'b0;
        end else begin
          case (state_q)
            S_COUNT: begin
              // Saturate rather than wrap; a lowered threshold still fires.
              cnt_d = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
              if (cnt_inc >= {1'b0, thresh_eff}) begin
                state_d  = S_FIRE;
                pulse_d  = 1'b1;
                active_d = 1'b1;
              end
            end
            S_FIRE, S_HOLD: begin
              if (mode) begin
                // Periodic: start a new segment of the same run.
                cnt_d = CNT_W'(1);
                if (t_is_one) begin
                  state_d  = S_FIRE;
                  pulse_d  = 1'b1;
                  active_d = 1'b1;
                end else begin
                  state_d = S_COUNT;
                end
              end else begin
                state_d = S_HOLD;
              end
            end
            default: begin // S_IDLE
              cnt_d = CNT_W'(1);
              if (t_is_one) begin
                state_d  = S_FIRE;
                pulse_d  = 1'b1;
                active_d = 1'b1;
              end else begin
                state_d = S_COUNT;
              end
            end
          endcase
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        pulse_q  <= 1'b0;
        active_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        pulse_q  <= pulse_d;
        active_q <= active_d;
      end
    end

    assign pulse_d_vec[gi] = pulse_d;
    assign pulse[gi]       = pulse_q;
    assign active[gi]      = active_q;

`ifdef RUN_LENGTH_DETECTOR_HITCNT_EN
    logic [7:0] hit_cnt_q;

    // Uses pulse_d so the count moves on the same edge that raises pulse.
    always_ff @(posedge clk) begin
      if (reset || hit_clr) begin
        hit_cnt_q <= '0;
      end else if (pulse_d && (hit_cnt_q != 8'hFF)) begin
        hit_cnt_q <= hit_cnt_q + 8'd1;
      end
    end

    assign hit_cnt[8*gi +: 8] = hit_cnt_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_pulse_q <= 1'b0;
    end else begin
      any_pulse_q <= |pulse_d_vec;
    end
  end

  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_run_length_detector.sv
module tb_run_length_detector;
  localparam int CH    = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [CH-1:0]    in_v;
  logic [CNT_W-1:0] thresh;
  logic             mode;
  logic [CH-1:0]    pulse0, active0, pulse1, active1;
  logic             any0, any1;
`ifdef RUN_LENGTH_DETECTOR_HITCNT_EN
  logic             hit_clr;
  logic [CH*8-1:0]  hc0, hc1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_length_detector #(.CH(CH), .CNT_W(CNT_W), .POLARITY(1'b0)) u_p0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_v),
    .thresh(thresh), .mode(mode),
    .pulse(pulse0), .active(active0), .any_pulse(any0)
`ifdef RUN_LENGTH_DETECTOR_HITCNT_EN
    , .hit_clr(hit_clr), .hit_cnt(hc0)
`endif
  );

  run_length_detector #(.CH(CH), .CNT_W(CNT_W), .POLARITY(1'b1)) u_p1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_v),
    .thresh(thresh), .mode(mode),
    .pulse(pulse1), .active(active1), .any_pulse(any1)
`ifdef RUN_LENGTH_DETECTOR_HITCNT_EN
    , .hit_clr(hit_clr), .hit_cnt(hc1)
`endif
  );

  // Reference model: per channel, the number of run samples in the current
  // segment toward the next pulse, whether the last pulse is still "latched"
  // (one-shot hold, or awaiting a periodic restart), and the active level.
  int seg     [2][CH];
  bit latched [2][CH];
  bit m_act   [2][CH];
  bit m_pul   [2][CH];
  int m_hc    [2][CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int t;
    t = (thresh == 0) ? 1 : int'(thresh);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < CH; c++) begin
        m_pul[k][c] = 1'b0;
        if (reset) begin
          seg[k][c] = 0; latched[k][c] = 1'b0; m_act[k][c] = 1'b0;
        end else if (in_valid) begin
          if (in_v[c] != k[0]) begin
            seg[k][c] = 0; latched[k][c] = 1'b0; m_act[k][c] = 1'b0;
          end else if (!(latched[k][c] && !mode)) begin
            seg[k][c] = latched[k][c] ? 1 : seg[k][c] + 1;
            latched[k][c] = 1'b0;
            if (seg[k][c] >= t) begin
              m_pul[k][c] = 1'b1; m_act[k][c] = 1'b1; latched[k][c] = 1'b1;
            end
          end
        end
`ifdef RUN_LENGTH_DETECTOR_HITCNT_EN
        if (reset || hit_clr) m_hc[k][c] = 0;
        else if (m_pul[k][c] && m_hc[k][c] < 255) m_hc[k][c]++;
`endif
      end
    end
  endtask

  task automatic compare();
    logic [CH-1:0] ep0, ea0, ep1, ea1;
    for (int c = 0; c < CH; c++) begin
      ep0[c] = m_pul[0][c]; ea0[c] = m_act[0][c];
      ep1[c] = m_pul[1][c]; ea1[c] = m_act[1][c];
    end
    check("p0_pulse",  32'(pulse0),  32'(ep0));
    check("p0_active", 32'(active0), 32'(ea0));
    check("p0_any",    32'(any0),    32'(|ep0));
    check("p1_pulse",  32'(pulse1),  32'(ep1));
    check("p1_active", 32'(active1), 32'(ea1));
    check("p1_any",    32'(any1),    32'(|ep1));
`ifdef RUN_LENGTH_DETECTOR_HITCNT_EN
    for (int c = 0; c < CH; c++) begin
      check("p0_hitcnt", 32'(hc0[8*c +: 8]), 32'(m_hc[0][c]));
      check("p1_hitcnt", 32'(hc1[8*c +: 8]), 32'(m_hc[1][c]));
    end
`endif
  endtask

  // One clock: model and DUT both consume the inputs on the edge; outputs
  // are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  int         cnt_p, cnt_a;
  logic [8:0] mask;
  logic [7:0] pat;

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_v = 4'b1111; thresh = 4'd8; mode = 1'b0;
`ifdef RUN_LENGTH_DETECTOR_HITCNT_EN
    hit_clr = 1'b0;
`endif
    tick(); tick();
    check("rst_pulse",  32'(pulse0),  32'd0);
    check("rst_active", 32'(active0), 32'd0);
    check("rst_any",    32'(any0),    32'd0);
    reset = 1'b0;
    tick();

    // Eight zeros on ch0, then a one.
    for (int i = 1; i <= 8; i++) begin
      in_v = 4'b1110; tick();
      if (i == 7) check("t1_early", 32'(pulse0[0]), 32'd0);
    end
    check("t1_pulse",  32'(pulse0[0]),  32'd1);
    check("t1_active", 32'(active0[0]), 32'd1);
    check("t1_any",    32'(any0),       32'd1);
    in_v = 4'b1111; tick();
    check("t1_pulse_end",  32'(pulse0[0]),  32'd0);
    check("t1_active_end", 32'(active0[0]), 32'd0);

    // Twenty zeros on ch1, one-shot.
    cnt_p = 0; cnt_a = 0;
    for (int i = 1; i <= 20; i++) begin
      in_v = 4'b1101; tick();
      cnt_p += int'(pulse0[1]); cnt_a += int'(active0[1]);
    end
    check("t2_pulses", 32'(cnt_p), 32'd1);
    check("t2_active", 32'(cnt_a), 32'd13);
    in_v = 4'b1111; tick();

    // Periodic mode, thresh 3, nine zeros on ch2.
    thresh = 4'd3; mode = 1'b1; mask = '0;
    for (int i = 0; i < 9; i++) begin
      in_v = 4'b1011; tick(); mask[i] = pulse0[2];
    end
    check("t3_mask", 32'(mask), 32'b100100100);
    in_v = 4'b1111; mode = 1'b0; tick();

    // Broken run on ch3, thresh 4.
    thresh = 4'd4; pat = 8'b0000_1000; mask = '0;
    for (int i = 0; i < 8; i++) begin
      in_v = {pat[i], 3'b111}; tick(); mask[i] = pulse0[3];
    end
    check("t4_mask", 32'(mask[7:0]), 32'b1000_0000);
    in_v = 4'b1111; tick();
    // Valid gap of 5 cycles in the middle of a run.
    mask = '0;
    for (int i = 0; i < 9; i++) begin
      in_valid = !(i >= 2 && i < 7);
      in_v = 4'b0111; tick(); mask[i] = pulse0[3];
    end
    check("t4_gap_mask", 32'(mask), 32'b1_0000_0000);
    in_valid = 1'b1; in_v = 4'b1111; tick();

    // thresh 0 on the POLARITY=1 instance: a single one fires.
    thresh = 4'd0; in_v = 4'b0000; tick();
    in_v = 4'b0001; tick();
    check("t5_pulse", 32'(pulse1[0]), 32'd1);
    in_v = 4'b0000; tick();
    check("t5_pulse_end", 32'(pulse1[0]), 32'd0);

    // Reset during a 6-of-8 run.
    thresh = 4'd8; in_v = 4'b1111; tick();
    for (int i = 0; i < 6; i++) begin
      in_v = 4'b1110; tick();
    end
    reset = 1'b1; tick();
    check("t6_rst_pulse", 32'(pulse0), 32'd0);
    reset = 1'b0; mask = '0;
    for (int i = 0; i < 8; i++) begin
      tick(); mask[i] = pulse0[0];
    end
    check("t6_mask", 32'(mask[7:0]), 32'b1000_0000);
    in_v = 4'b1111; tick();

`ifdef RUN_LENGTH_DETECTOR_HITCNT_EN
    thresh = 4'd1; mode = 1'b1; in_v = 4'b1110;
    for (int i = 0; i < 300; i++) tick();
    check("hc_sat", 32'(hc0[7:0]), 32'd255);
    hit_clr = 1'b1; tick(); hit_clr = 1'b0;
    check("hc_clr", 32'(hc0[7:0]), 32'd0);
    mode = 1'b0; in_v = 4'b1111; tick();
`endif

    // Randomised traffic; the model checks every cycle.
    begin
      logic [CH-1:0] lvl;
      lvl = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
        if (i % 40 == 0) lvl = 4'($urandom);
        for (int c = 0; c < CH; c++)
          in_v[c] = ($urandom_range(0, 5) != 0) ? lvl[c] : ~lvl[c];
        in_valid = ($urandom_range(0, 99) < 85);
        if ($urandom_range(0, 99) < 3) thresh = 4'($urandom_range(0, 6));
        if ($urandom_range(0, 99) < 2) mode = ~mode;
        reset = ($urandom_range(0, 999) < 5);
`ifdef RUN_LENGTH_DETECTOR_HITCNT_EN
        hit_clr = ($urandom_range(0, 99) < 1);
`endif
        tick();
      end
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
